// File: rtl/sync_seq_ctrl_if.sv
// Handshake and control bundle for sync_seq_ctrl.
// The master side drives the pattern, ready, abort and burst length;
// the slave side (the controller) returns the toggles, enable and status.
interface sync_seq_ctrl_if #(
  parameter int BURST_W = 8
);
  logic               arm;
  logic               confirm;
  logic               rdy;
  logic               abort;
  logic [BURST_W-1:0] burst_len;
  logic               match_tgl;
  logic               rdy_tgl;
  logic               enb;
  logic               busy;
  logic               done;

  modport master (
    output arm, confirm, rdy, abort, burst_len,
    input  match_tgl, rdy_tgl, enb, busy, done
  );

  modport slave (
    input  arm, confirm, rdy, abort, burst_len,
    output match_tgl, rdy_tgl, enb, busy, done
  );
endinterface

// File: rtl/sync_seq_ctrl.sv
// Sequencing controller: arm/confirm pattern detect, ready handshake,
// fixed settle interval, then a programmable enable burst. Abortable.
// All outputs come from registers or from the registered state only.
module sync_seq_ctrl #(
  parameter int GAP     = 2,
  parameter int SETTLE  = 5,
  parameter int BURST_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  sync_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_RDY,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0]         GAP_C    = 4'(GAP);
  localparam logic [7:0]         SET_LAST = 8'(SETTLE - 1);
  localparam logic [BURST_W-1:0] RUN_ONE  = BURST_W'(1);

  state_t             state, state_n;
  logic [3:0]         gap_cnt, gap_n;
  logic [7:0]         set_cnt, set_n;
  logic [BURST_W-1:0] run_cnt, run_n;
  logic               match_tgl, mt_n;
  logic               rdy_tgl, rt_n;
  logic               enb, enb_n;

  // State, counters, toggles and enable all update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      set_cnt   <= '0;
      run_cnt   <= '0;
      match_tgl <= 1'b0;
      rdy_tgl   <= 1'b0;
      enb       <= 1'b0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      set_cnt   <= set_n;
      run_cnt   <= run_n;
      match_tgl <= mt_n;
      rdy_tgl   <= rt_n;
      enb       <= enb_n;
    end
  end

  // Next-state logic; abort overrides everything, including a same-edge confirm.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    set_n   = set_cnt;
    run_n   = run_cnt;
    mt_n    = match_tgl;
    rt_n    = rdy_tgl;
    enb_n   = enb;
    if (bus.abort) begin
      state_n = S_IDLE;
      gap_n   = '0;
      set_n   = '0;
      run_n   = '0;
      enb_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.arm) begin
            state_n = S_ARMED;
            gap_n   = 4'd1;
          end
        end
        S_ARMED: begin
          if (gap_cnt != GAP_C) begin
            gap_n = gap_cnt + 4'd1;
          end else begin
            gap_n = '0;
            if (bus.confirm) begin
              mt_n    = ~match_tgl;
              state_n = S_WAIT_RDY;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_WAIT_RDY: begin
          if (bus.rdy) begin
            rt_n    = ~rdy_tgl;
            set_n   = '0;
            state_n = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (set_cnt == SET_LAST) begin
            set_n = '0;
            run_n = bus.burst_len;
            // A zero-length burst skips RUN so enb never pulses.
            if (bus.burst_len != '0) begin
              enb_n   = 1'b1;
              state_n = S_RUN;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            set_n = set_cnt + 8'd1;
          end
        end
        S_RUN: begin
          // run_cnt holds the cycles of enb still owed, including this one.
          if (run_cnt <= RUN_ONE) begin
            run_n   = '0;
            enb_n   = 1'b0;
            state_n = S_DONE;
          end else begin
            run_n = run_cnt - RUN_ONE;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          enb_n   = 1'b0;
        end
      endcase
    end
  end

  assign bus.match_tgl = match_tgl;
  assign bus.rdy_tgl   = rdy_tgl;
  assign bus.enb       = enb;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);

endmodule
